// File: rtl/ri_weight_stream.sv
// ri_weight_stream: writable two-bank recurrent-weight store for the LSTM layers.
// One bank can be reloaded through the write port while the other streams a
// contiguous row range to the MAC array over a registered valid/ready output.
module ri_weight_stream #(
    parameter int D_WL      = 24,
    parameter int UNITS_NUM = 5,
    parameter int DEPTH     = 180,
    parameter int AW        = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic                      wr_bank,
    input  logic [AW-1:0]             wr_addr,
    input  logic [UNITS_NUM*D_WL-1:0] wr_data,
    input  logic                      start,
    input  logic                      rd_bank,
    input  logic [AW-1:0]             base_addr,
    input  logic [AW:0]               len,
    output logic [UNITS_NUM*D_WL-1:0] w_o,
    output logic                      w_valid,
    input  logic                      w_ready,
    output logic                      w_last,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int ROW_W = UNITS_NUM * D_WL;

    // Range arithmetic carries two bits of headroom so that even a maximal
    // base_addr plus a maximal len cannot wrap back into the legal range.
    localparam logic [AW+1:0] DEPTH_X = (AW + 2)'(DEPTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Weight storage, not reset so contents survive a reset pulse
    logic [ROW_W-1:0] mem [2][DEPTH];

    state_t           state_q, state_d;
    logic             bank_q, bank_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [AW:0]      rem_q, rem_d;
    logic [ROW_W-1:0] w_o_d;
    logic             w_valid_d;
    logic             w_last_d;
    logic             busy_d;
    logic             done_d;
    logic             err_d;

    logic [AW+1:0]    range_end;
    logic             wr_in_range;

    assign range_end   = (AW + 2)'(base_addr) + (AW + 2)'(len);
    assign wr_in_range = ((AW + 2)'(wr_addr) < DEPTH_X);

    // Synchronous row write; out-of-range addresses are dropped. A read of the
    // same row on the same edge sees the old contents (read-before-write).
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    // State, stream pointers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bank_q  <= 1'b0;
            ptr_q   <= '0;
            rem_q   <= '0;
            w_o     <= '0;
            w_valid <= 1'b0;
            w_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            w_o     <= w_o_d;
            w_valid <= w_valid_d;
            w_last  <= w_last_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    // Next-state logic: start validation in IDLE, beat issue and stream close in RUN
    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        w_o_d     = w_o;
        w_valid_d = w_valid;
        w_last_d  = w_last;
        busy_d    = busy;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((len == '0) || (range_end > DEPTH_X)) begin
                        err_d = 1'b1;
                    end else begin
                        bank_d  = rd_bank;
                        ptr_d   = base_addr;
                        rem_d   = len;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if ((!w_valid || w_ready) && (rem_q != '0)) begin
                    w_o_d     = mem[bank_q][ptr_q];
                    w_valid_d = 1'b1;
                    w_last_d  = (rem_q == (AW + 1)'(1));
                    ptr_d     = ptr_q + AW'(1);
                    rem_d     = rem_q - (AW + 1)'(1);
                end else if (w_valid && w_ready && (rem_q == '0)) begin
                    w_valid_d = 1'b0;
                    w_last_d  = 1'b0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ri_weight_stream.sv
// tb_ri_weight_stream: scoreboard bench for ri_weight_stream. Expected rows are
// snapshotted from a plain array model when a stream starts; a monitor process
// compares every presented beat against the head of the queue.
module tb_ri_weight_stream;

    localparam int D_WL      = 24;
    localparam int UNITS_NUM = 5;
    localparam int DEPTH     = 180;
    localparam int AW        = 8;
    localparam int ROW_W     = UNITS_NUM * D_WL;

    typedef logic [ROW_W-1:0] row_t;
    typedef struct packed {
        row_t data;
        logic last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en = 1'b0;
    logic          wr_bank = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    row_t          wr_data = '0;
    logic          start = 1'b0;
    logic          rd_bank = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    row_t          w_o;
    logic          w_valid;
    logic          w_ready = 1'b0;
    logic          w_last;
    logic          busy;
    logic          done;
    logic          err;

    int    checks = 0;
    int    passes = 0;
    row_t  model [2][DEPTH];
    beat_t sbq [$];

    ri_weight_stream #(
        .D_WL(D_WL), .UNITS_NUM(UNITS_NUM), .DEPTH(DEPTH), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .rd_bank(rd_bank), .base_addr(base_addr), .len(len),
        .w_o(w_o), .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input row_t actual, input row_t expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    endtask

    function automatic row_t fill(input logic [D_WL-1:0] v);
        return {UNITS_NUM{v}};
    endfunction

    function automatic row_t randRow();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[ROW_W-1:0];
    endfunction

    function automatic bit isLegal(input int b, input int l);
        return (l != 0) && (b + l <= DEPTH);
    endfunction

    task automatic writeRow(input logic bank, input int addr, input row_t data);
        wr_en   = 1'b1;
        wr_bank = bank;
        wr_addr = AW'(addr);
        wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (addr < DEPTH) model[bank][addr] = data;
    endtask

    task automatic pushExpected(input logic bank, input int b, input int l);
        for (int i = 0; i < l; i++) begin
            sbq.push_back('{data: model[bank][b + i], last: (i == l - 1)});
        end
    endtask

    // One legal stream. readyMode: 0 always ready, 1 random, 2 low where stallMask is set.
    // Optional write during cycle wrCycle and a stray start during cycle busyStartCycle.
    task automatic applyStimulus(input logic bank, input int sBase, input int sLen,
                                 input int readyMode, input logic [63:0] stallMask,
                                 input int wrCycle, input logic wrBank, input int wrAddr,
                                 input row_t wrData, input int busyStartCycle);
        int   accepted;
        int   doneCycle;
        logic r;
        accepted  = 0;
        doneCycle = -1;
        pushExpected(bank, sBase, sLen);
        start     = 1'b1;
        rd_bank   = bank;
        base_addr = AW'(sBase);
        len       = (AW + 1)'(sLen);
        @(posedge clk); #1;
        start   = 1'b0;
        w_ready = 1'b0;
        @(negedge clk);
        checkOutput("busy after start", busy, 1);
        checkOutput("no valid before latency", w_valid, 0);
        checkOutput("no err on legal start", err, 0);
        for (int k = 1; k < 4000; k++) begin
            @(posedge clk); #1;
            wr_en = 1'b0;
            start = 1'b0;
            if (readyMode == 0) r = 1'b1;
            else if (readyMode == 2) r = (k < 64) ? !stallMask[k] : 1'b1;
            else r = ($urandom_range(3) != 0);
            if (k > 4 * sLen + 8) r = 1'b1;
            w_ready = r;
            if (k == wrCycle) begin
                wr_en   = 1'b1;
                wr_bank = wrBank;
                wr_addr = AW'(wrAddr);
                wr_data = wrData;
                model[wrBank][wrAddr] = wrData;
            end
            if (k == busyStartCycle) begin
                start     = 1'b1;
                rd_bank   = ~bank;
                base_addr = '0;
                len       = (AW + 1)'(1);
            end
            @(negedge clk);
            checkOutput("done timing", done, (k == doneCycle));
            checkOutput("busy timing", busy, (doneCycle < 0));
            checkOutput("valid timing", w_valid, (doneCycle < 0));
            checkOutput("no err in stream", err, 0);
            if (k == doneCycle) break;
            if (r && accepted < sLen) begin
                accepted++;
                if (accepted == sLen) doneCycle = k + 1;
            end
        end
        checkOutput("scoreboard drained", row_t'(sbq.size()), 0);
    endtask

    task automatic expectReject(input logic bank, input int b, input int l);
        start     = 1'b1;
        rd_bank   = bank;
        base_addr = AW'(b);
        len       = (AW + 1)'(l);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("err pulse", err, 1);
        checkOutput("busy after reject", busy, 0);
        checkOutput("no done after reject", done, 0);
        checkOutput("no valid after reject", w_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("err single cycle", err, 0);
        checkOutput("busy stays low", busy, 0);
    endtask

    task automatic resetMidStream(input logic bank, input int b);
        pushExpected(bank, b, 8);
        start     = 1'b1;
        rd_bank   = bank;
        base_addr = AW'(b);
        len       = (AW + 1)'(8);
        @(posedge clk); #1;
        start   = 1'b0;
        w_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset kills valid", w_valid, 0);
        checkOutput("reset kills busy", busy, 0);
        checkOutput("reset no done", done, 0);
        checkOutput("reset clears w_o", w_o, 0);
        checkOutput("reset clears last", w_last, 0);
        sbq.delete();
        repeat (3) begin
            @(negedge clk);
            checkOutput("no done in reset", done, 0);
            checkOutput("idle in reset", busy, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Monitor: compare each presented beat with the scoreboard head, pop on acceptance
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && w_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected beat", 1, 0);
                end else begin
                    checkOutput("row data", w_o, sbq[0].data);
                    checkOutput("last flag", w_last, sbq[0].last);
                    if (w_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    // Main sequence: directed cases from the plan followed by randomized streams
    initial begin : stimulus
        int b, l;
        logic bk;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset w_o", w_o, 0);
        checkOutput("reset w_valid", w_valid, 0);
        checkOutput("reset w_last", w_last, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int bank = 0; bank < 2; bank++) begin
            for (int a = 0; a < DEPTH; a++) writeRow(bank[0], a, randRow());
        end

        $display("[TB] basic stream");
        for (int i = 0; i < 4; i++) writeRow(1'b0, i, fill(D_WL'(i + 1)));
        applyStimulus(1'b0, 0, 4, 0, '0, -1, 1'b0, 0, '0, -1);
        @(posedge clk); #1;

        $display("[TB] backpressure stream");
        applyStimulus(1'b0, 0, 4, 2, 64'h0C, -1, 1'b0, 0, '0, -1);
        @(posedge clk); #1;

        $display("[TB] illegal starts");
        expectReject(1'b0, 0, 0);
        expectReject(1'b0, 179, 2);
        expectReject(1'b1, 200, 1);
        expectReject(1'b1, 255, 511);
        applyStimulus(1'b0, 179, 1, 0, '0, -1, 1'b0, 0, '0, -1);
        applyStimulus(1'b0, 4, 4, 0, '0, -1, 1'b0, 0, '0, 2);

        $display("[TB] ping-pong");
        applyStimulus(1'b1, 10, 10, 0, '0, 3, 1'b0, 10, fill(24'h7FFFFF), -1);
        applyStimulus(1'b0, 10, 1, 0, '0, -1, 1'b0, 0, '0, -1);

        $display("[TB] collision");
        applyStimulus(1'b0, 0, 4, 0, '0, 2, 1'b0, 2, fill(24'hABCDEF), -1);
        applyStimulus(1'b0, 2, 1, 0, '0, -1, 1'b0, 0, '0, -1);

        $display("[TB] back-to-back");
        applyStimulus(1'b1, 0, 3, 0, '0, -1, 1'b0, 0, '0, -1);
        applyStimulus(1'b0, 5, 2, 1, '0, -1, 1'b0, 0, '0, -1);

        $display("[TB] reset mid-stream");
        for (int i = 20; i < 28; i++) writeRow(1'b0, i, randRow());
        resetMidStream(1'b0, 20);
        applyStimulus(1'b0, 20, 8, 0, '0, -1, 1'b0, 0, '0, -1);

        $display("[TB] random streams");
        for (int n = 0; n < 40; n++) begin
            bk = 1'($urandom_range(1));
            b  = $urandom_range(0, 185);
            l  = $urandom_range(0, 12);
            if ($urandom_range(7) == 0) b = $urandom_range(0, 255);
            if ($urandom_range(9) == 0) l = $urandom_range(0, 511);
            if (isLegal(b, l)) begin
                applyStimulus(bk, b, l, 1, '0, 1, ~bk, $urandom_range(0, DEPTH - 1), randRow(), -1);
            end else begin
                expectReject(bk, b, l);
            end
            if ($urandom_range(1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
